// File: rtl/light_dance_sequencer_pkg.sv
// Shared types and constants for the LightDance sequencer.
package light_dance_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } ld_state_e;

  localparam logic [1:0] DIN_ZERO   = 2'b00;
  localparam logic [1:0] DIN_ONE    = 2'b01;
  localparam logic [1:0] DIN_TOGGLE = 2'b10;
  localparam logic [1:0] DIN_EXT    = 2'b11;

endpackage

// File: rtl/light_dance_sequencer_if.sv
// Control/status bundle between the system controller, the sequencer and the LightDance register.
interface light_dance_sequencer_if #(
  parameter int STEP_W = 8,
  parameter int DIV_W  = 16
);
  logic              start;
  logic              abort;
  logic              pause;
  logic [7:0]        seed;
  logic [STEP_W-1:0] step_count;
  logic [DIV_W-1:0]  div;
  logic [1:0]        din_mode;
  logic              ext_din;
  logic [7:0]        ld_qdata;
  logic              ld_load;
  logic [7:0]        ld_pdata;
  logic              ld_din;
  logic              busy;
  logic              done;
  logic [STEP_W-1:0] steps_done;

  modport master (
    output start, abort, pause, seed, step_count, div, din_mode, ext_din, ld_qdata,
    input  ld_load, ld_pdata, ld_din, busy, done, steps_done
  );

  modport slave (
    input  start, abort, pause, seed, step_count, div, din_mode, ext_din, ld_qdata,
    output ld_load, ld_pdata, ld_din, busy, done, steps_done
  );
endinterface

// File: rtl/light_dance_tick_div.sv
// Rate divider: counts 0..term_i while enabled and flags the terminal cycle.
module light_dance_tick_div #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] term_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == term_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (tick_o) cnt_d = '0;
    else if (en_i)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (arst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/light_dance_sequencer.sv
// Seeds the LightDance register, then releases it for step_count shifts at a divided rate.
//   state | meaning
//   IDLE  | holding register, waiting for start
//   LOAD  | one cycle driving the captured seed into the register
//   RUN   | dividing the clock, releasing one shift per tick
//   DONE  | one-cycle completion pulse
module light_dance_sequencer
  import light_dance_pkg::*;
#(
  parameter int STEP_W = 8,
  parameter int DIV_W  = 16
) (
  input logic clk,
  input logic arst,
  light_dance_sequencer_if.slave bus
);

  ld_state_e         state_q;
  logic [7:0]        seed_q;
  logic [STEP_W-1:0] step_count_q;
  logic [DIV_W-1:0]  div_q;
  logic [1:0]        din_mode_q;
  logic [STEP_W-1:0] steps_q;
  logic [STEP_W-1:0] steps_inc;
  logic              tog_q;
  logic              busy_q;
  logic              done_q;
  logic              tick;
  logic              div_en;

  assign div_en    = (state_q == ST_RUN) && !bus.pause && !bus.abort;
  assign steps_inc = steps_q + 1'b1;

  light_dance_tick_div #(.DIV_W(DIV_W)) u_div (
    .clk    (clk),
    .arst   (arst),
    .clr_i  (state_q == ST_LOAD),
    .en_i   (div_en),
    .term_i (div_q),
    .tick_o (tick)
  );

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q      <= ST_IDLE;
      seed_q       <= '0;
      step_count_q <= '0;
      div_q        <= '0;
      din_mode_q   <= '0;
      steps_q      <= '0;
      tog_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start && !bus.abort) begin
            seed_q       <= bus.seed;
            step_count_q <= bus.step_count;
            div_q        <= bus.div;
            din_mode_q   <= bus.din_mode;
            busy_q       <= 1'b1;
            state_q      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          steps_q <= '0;
          tog_q   <= 1'b0;
          if (bus.abort) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (step_count_q == '0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.abort) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (tick) begin
            steps_q <= steps_inc;
            tog_q   <= ~tog_q;
            if (steps_inc == step_count_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Only a RUN tick lets the register shift; otherwise it reloads its own value.
  assign bus.ld_load    = !tick;
  assign bus.ld_pdata   = (state_q == ST_LOAD) ? seed_q : bus.ld_qdata;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.steps_done = steps_q;

  always_comb begin
    bus.ld_din = 1'b0;
    case (din_mode_q)
      DIN_ZERO:   bus.ld_din = 1'b0;
      DIN_ONE:    bus.ld_din = 1'b1;
      DIN_TOGGLE: bus.ld_din = tog_q;
      DIN_EXT:    bus.ld_din = bus.ext_din;
      default:    bus.ld_din = 1'b0;
    endcase
  end

endmodule
